// File: rtl/sec_keyed_pipe.sv
// sec_keyed_pipe: two-stage valid/ready single-error-correcting decoder.
// The corrected word is XOR-masked with a key that is shifted in serially,
// MSB first, through a small LOCKED/LOAD/RUN controller. Words are accepted
// only in RUN.
module sec_keyed_pipe #(
    parameter int               DATA_W  = 32,
    parameter int               CHK_W   = 8,
    parameter int               KEY_W   = 24,
    parameter logic [KEY_W-1:0] KEY_POL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start,
    input  logic              key_vld,
    input  logic              key_bit,
    output logic              key_loaded,
    input  logic              chk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_chk_err,
    output logic              out_uncorr
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    typedef logic [DATA_W-1:0][CHK_W-1:0] col_tab_t;
    typedef enum logic [1:0] {ST_LOCKED, ST_LOAD, ST_RUN} state_t;

    // Column i is the i-th non-power-of-two in [1, 2**CHK_W); powers of two
    // are reserved for the check bits themselves.
    function automatic col_tab_t gen_cols();
        col_tab_t tab;
        int       n;
        tab = '0;
        n   = 0;
        for (int v = 1; v < (1 << CHK_W); v++) begin
            if (((v & (v - 1)) != 0) && (n < DATA_W)) begin
                tab[n] = CHK_W'(v);
                n      = n + 1;
            end
        end
        return tab;
    endfunction

    localparam col_tab_t COLS = gen_cols();

    // Controller state and key register
    state_t             r_state;
    state_t             w_state_nxt;
    logic [KEY_W-1:0]   r_key;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load_go;
    logic               w_shift;

    // Pipeline registers
    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_s1_data;
    logic [CHK_W-1:0]   r_s1_syn_d;
    logic [CHK_W-1:0]   r_s1_chk;
    logic               r_s2_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_corr;
    logic               r_out_chk_err;
    logic               r_out_uncorr;

    // Combinational datapath
    logic               w_advance;
    logic               w_accept;
    logic               w_pipe_empty;
    logic [CHK_W-1:0]   w_syn_d;
    logic [CHK_W-1:0]   w_chk_g;
    logic [CHK_W-1:0]   w_syn;
    logic [DATA_W-1:0]  w_corr_data;
    logic               w_corr;
    logic               w_chk_err;
    logic               w_uncorr;
    logic [DATA_W-1:0]  w_mask;

    assign w_advance    = !r_s2_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_pipe_empty = !r_s1_valid && !r_s2_valid;

    assign in_ready     = w_advance && (r_state == ST_RUN);
    assign key_loaded   = (r_state == ST_RUN);
    assign out_valid    = r_s2_valid;
    assign out_data     = r_out_data;
    assign out_corr     = r_out_corr;
    assign out_chk_err  = r_out_chk_err;
    assign out_uncorr   = r_out_uncorr;

    // Next-state logic; a reload is only honoured with the pipeline drained so
    // no in-flight word is masked by a half-shifted key.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_load_go   = 1'b0;
        w_shift     = 1'b0;
        unique case (r_state)
            ST_LOCKED, ST_RUN: begin
                if (key_start && w_pipe_empty) begin
                    w_load_go   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (key_vld) begin
                    w_shift = 1'b1;
                    if (r_cnt == CNT_W'(KEY_W - 1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_state_nxt = ST_LOCKED;
        endcase
    end

    // State register, key shift register and bit counter
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_LOCKED;
            r_key   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_go) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                r_key <= (r_key << 1) | KEY_W'(key_bit);
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Stage-1 inputs: data-only syndrome and gated check bits
    always_comb begin
        w_syn_d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (in_data[i]) begin
                w_syn_d = w_syn_d ^ COLS[i];
            end
        end
        w_chk_g = chk_en ? in_chk : '0;
    end

    // Stage-2 decode: classify the syndrome and flip at most one data bit
    always_comb begin
        w_syn       = r_s1_syn_d ^ r_s1_chk;
        w_corr_data = r_s1_data;
        w_corr      = 1'b0;
        w_chk_err   = 1'b0;
        w_uncorr    = 1'b0;
        if (w_syn != '0) begin
            if ((w_syn & (w_syn - CHK_W'(1))) == '0) begin
                w_chk_err = 1'b1;
            end else begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (w_syn == COLS[i]) begin
                        w_corr_data[i] = ~r_s1_data[i];
                        w_corr         = 1'b1;
                    end
                end
                w_uncorr = !w_corr;
            end
        end
    end

    // Key mask covers only the low KEY_W data bits
    always_comb begin
        w_mask             = '0;
        w_mask[KEY_W-1:0]  = r_key ^ KEY_POL;
    end

    // Two-stage pipeline; both stages hold together when stage 2 is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_syn_d    <= '0;
            r_s1_chk      <= '0;
            r_s2_valid    <= 1'b0;
            r_out_data    <= '0;
            r_out_corr    <= 1'b0;
            r_out_chk_err <= 1'b0;
            r_out_uncorr  <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid    <= w_accept;
            r_s1_data     <= in_data;
            r_s1_syn_d    <= w_syn_d;
            r_s1_chk      <= w_chk_g;
            r_s2_valid    <= r_s1_valid;
            r_out_data    <= w_corr_data ^ w_mask;
            r_out_corr    <= w_corr;
            r_out_chk_err <= w_chk_err;
            r_out_uncorr  <= w_uncorr;
        end
    end

endmodule

// File: tb/tb_sec_keyed_pipe.sv
// Testbench for sec_keyed_pipe at default parameters (32 data, 8 check,
// 24 key bits, KEY_POL = 0). Expected words go into a scoreboard queue when
// the DUT accepts them; a monitor pops and compares at each output handshake.
module tb_sec_keyed_pipe;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  f;     // {corr, chk_err, uncorr}
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  chk;
        logic        en;
        logic [31:0] xd;
        logic [2:0]  xf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_start = 1'b0;
    logic        key_vld = 1'b0;
    logic        key_bit = 1'b0;
    logic        key_loaded;
    logic        chk_en = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [7:0]  in_chk = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_corr;
    logic        out_chk_err;
    logic        out_uncorr;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;
    exp_t sb[$];
    vec_t vt[13];

    sec_keyed_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .key_vld    (key_vld),
        .key_bit    (key_bit),
        .key_loaded (key_loaded),
        .chk_en     (chk_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_chk     (in_chk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_corr   (out_corr),
        .out_chk_err(out_chk_err),
        .out_uncorr (out_uncorr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference code: column search by counting non-powers of two
    function automatic logic [7:0] col_model(input int i);
        int cnt = -1;
        int v = 0;
        while (cnt < i) begin
            v++;
            if ((v & (v - 1)) != 0) cnt++;
        end
        return 8'(v);
    endfunction

    function automatic logic [7:0] enc(input logic [31:0] d);
        logic [7:0] s = '0;
        for (int i = 0; i < 32; i++) if (d[i]) s ^= col_model(i);
        return s;
    endfunction

    // Output monitor: compare every completed output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", out_data, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("out%0d data", n_out), out_data, e.d);
                check($sformatf("out%0d flags", n_out),
                      {29'd0, out_corr, out_chk_err, out_uncorr}, {29'd0, e.f});
            end
            n_out++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        key_start = 1'b0;
        key_vld = 1'b0;
        repeat (2) tick();
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] c, input logic en,
                        input logic [31:0] xd, input logic [2:0] xf);
        bit done = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_chk   = c;
        chk_en   = en;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = xd;
                e.f = xf;
                sb.push_back(e);
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic load_key(input logic [23:0] key, input bit start_mid);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            key_vld   = 1'b1;
            key_bit   = key[23-i];
            key_start = start_mid && (i == 10);
            if (i == 23) begin
                @(negedge clk);
                check("key_loaded_before_last", {31'd0, key_loaded}, 32'd0);
            end
            tick();
        end
        key_vld   = 1'b0;
        key_start = 1'b0;
        @(negedge clk);
        check("key_loaded_after_load", {31'd0, key_loaded}, 32'd1);
        check("in_ready_after_load", {31'd0, in_ready}, 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  c;
        int          b;

        vt[0]  = '{32'h0000_0001, 8'h00, 1'b1, 32'h0000_0000, 3'b100};
        vt[1]  = '{32'h0000_0000, 8'h04, 1'b1, 32'h0000_0000, 3'b010};
        vt[2]  = '{32'h0000_0000, 8'hFF, 1'b1, 32'h0000_0000, 3'b001};
        vt[3]  = '{32'h0000_0000, 8'hFF, 1'b0, 32'h0000_0000, 3'b000};
        vt[4]  = '{32'h8000_0000, 8'h00, 1'b1, 32'h0000_0000, 3'b100};
        vt[5]  = '{32'h0000_0000, 8'h26, 1'b1, 32'h8000_0000, 3'b100};
        vt[6]  = '{32'h0000_0000, 8'h27, 1'b1, 32'h0000_0000, 3'b001};
        vt[7]  = '{32'h0000_0000, 8'h80, 1'b1, 32'h0000_0000, 3'b010};
        vt[8]  = '{32'h0000_0003, 8'h00, 1'b1, 32'h0000_0007, 3'b100};
        vt[9]  = '{32'h0000_0000, 8'h00, 1'b1, 32'h0000_0000, 3'b000};
        vt[10] = '{32'h8000_0000, 8'h26, 1'b1, 32'h8000_0000, 3'b000};
        vt[11] = '{32'h0000_0010, 8'h09, 1'b1, 32'h0000_0010, 3'b000};
        vt[12] = '{32'h0000_0000, 8'h01, 1'b1, 32'h0000_0000, 3'b010};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        check("rst key_loaded", {31'd0, key_loaded}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst flags", {29'd0, out_corr, out_chk_err, out_uncorr}, 32'd0);
        tick();

        // Load zero key; a key_start in the middle of LOAD must be ignored
        load_key(24'h000000, 1'b1);

        // Latency: stage 1 after accept, out_valid one edge later
        send(32'h0000_0001, 8'h00, 1'b1, 32'h0, 3'b100);
        @(negedge clk);
        check("latency s1 only", {31'd0, out_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("latency out_valid", {31'd0, out_valid}, 32'd1);
        tick();
        drain();

        // Table-driven vectors, back to back
        for (int i = 0; i < 13; i++) send(vt[i].data, vt[i].chk, vt[i].en, vt[i].xd, vt[i].xf);
        drain();

        // Encoded random words: clean, one data-bit error, one check-bit error
        for (int j = 0; j < 24; j++) begin
            d = $urandom();
            c = enc(d);
            case (j % 3)
                0: send(d, c, 1'b1, d, 3'b000);
                1: begin
                    b = $urandom_range(31, 0);
                    send(d ^ (32'd1 << b), c, 1'b1, d, 3'b100);
                end
                default: begin
                    b = $urandom_range(7, 0);
                    send(d, c ^ (8'd1 << b), 1'b1, d, 3'b010);
                end
            endcase
        end
        drain();

        // key_vld in RUN must not shift the key
        key_vld = 1'b1;
        key_bit = 1'b1;
        repeat (3) tick();
        key_vld = 1'b0;
        send(32'h0, 8'h00, 1'b1, 32'h0, 3'b000);
        drain();

        // Backpressure: two words fill the pipe, key_start ignored, outputs hold
        out_ready = 1'b0;
        send(32'hF0F0_F0F0, enc(32'hF0F0_F0F0), 1'b1, 32'hF0F0_F0F0, 3'b000);
        send(32'h0000_0000, 8'h10, 1'b1, 32'h0000_0000, 3'b010);
        @(negedge clk);
        check("bp in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp out_data", out_data, 32'hF0F0_F0F0);
            tick();
        end
        check("bp key_loaded", {31'd0, key_loaded}, 32'd1);
        drain();
        @(negedge clk);
        check("after bp in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Wrong key masks the output; upper bits stay unmasked
        load_key(24'h000001, 1'b0);
        send(32'h0, 8'h00, 1'b1, 32'h0000_0001, 3'b000);
        drain();
        load_key(24'hA5C381, 1'b0);
        send(32'hFF00_0000, enc(32'hFF00_0000), 1'b1, 32'hFFA5_C381, 3'b000);
        send(32'h0000_0010, 8'h00, 1'b1, 32'h00A5_C381, 3'b100);
        drain();

        // Reset mid-stream discards in-flight words
        out_ready = 1'b0;
        send(32'h1234_5678, 8'h00, 1'b1, 32'h0, 3'b000);
        send(32'h8765_4321, 8'h00, 1'b1, 32'h0, 3'b000);
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check("mid-stream rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid-stream rst out_data", out_data, 32'd0);
        check("mid-stream rst key_loaded", {31'd0, key_loaded}, 32'd0);
        tick();

        // Reset after 10 key bits: LOCKED, nothing accepted, stray key_vld ignored
        load_key(24'h000000, 1'b0);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        key_vld = 1'b1;
        key_bit = 1'b1;
        repeat (10) tick();
        key_vld = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h0;
        in_chk   = 8'h00;
        key_vld  = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k == 0 || k == 25) begin
                check("mid-load rst in_ready", {31'd0, in_ready}, 32'd0);
                check("mid-load rst key_loaded", {31'd0, key_loaded}, 32'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        key_vld  = 1'b0;
        @(negedge clk);
        check("mid-load rst out_valid", {31'd0, out_valid}, 32'd0);
        tick();

        // Reload and confirm recovery
        load_key(24'h000000, 1'b0);
        send(32'h0000_0100, 8'h00, 1'b1, 32'h0, 3'b100);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
